ibuf_rc: RTL
============

# ibuf_rc

Per-virtual-channel input buffer with route computation, sitting directly upstream of the `vc` controller in each router input port. It stores incoming flits in a FIFO and presents the head flit on `bdata`. It computes the XY output port for each packet from the head flit's destination and holds it stable on `port`/`ovch` until the packet's tail leaves. It pops one flit per cycle while the downstream `vc` is in switch traversal with grant and ready.

## Interface
- ROUTERID, 0, this router's id; x = ROUTERID % ARRAY_X, y = ROUTERID / ARRAY_X
- PCHID, 0, physical input channel id (informational only)
- VCHID, 0, virtual channel id; driven unchanged on `ovch`
- DEPTH, 4, FIFO depth in flits (power of two, ≥2)
- ARRAY_X, 4, mesh width in routers

Ports:
- clk  in  1  clock, the block's single clock
- rst  in  1  reset, asynchronous and active-high
- idata  in  `DATAW+1  incoming flit
- ivalid  in  1  `idata` valid this cycle
- ordy  out  1  buffer not full (upstream credit/ready)
- bdata  out  `DATAW+1  head flit to `vc`; all zeros when empty
- send  in  1  from `vc`: in switch traversal
- grt  in  1  crossbar grant for the selected port
- irdy  in  1  next-hop VC can accept a flit
- port  out  `PORTW+1  output port: 0 = +X, 1 = −X, 2 = +Y, 3 = −Y, 4 = local
- ovch  out  `VCHW+1  output VC, equal to VCHID
- ovf  out  1  sticky overflow flag (see Configuration)

## Operation
- Flit type is `bdata[`TYPE_MSB:`TYPE_LSB]`. Value 2'b00 means none, so an empty buffer never looks like a head flit.
- Destination id is `[`DST_MSB:`DST_LSB]` of head/headtail flits. dx = dst % ARRAY_X, dy = dst / ARRAY_X.
- XY routing, X first:
  - dx > x → 0; dx < x → 1.
  - Otherwise dy > y → 2; dy < y → 3.
  - Otherwise → 4.
- FIFO:
  - Write pointer, read pointer and count (0..DEPTH), each `clog2(DEPTH)+1` bits wide.
  - Pointers wrap modulo DEPTH.
  - push = ivalid & ordy; pop = send & grt & irdy & (count != 0).
- Route state machine (2 states):
  - IDLE: `port` is combinational XY(head) while the head flit is head or headtail; otherwise `port` holds its last value. A pop of a head flit latches `port` into the route register and moves to ROUTED. A pop of a headtail flit stays in IDLE.
  - ROUTED: `port` = route register, stable regardless of the current head. A pop of a tail flit returns to IDLE.
- Body/tail flits at the head while in IDLE are a protocol error. `port` holds its last value; no recovery is attempted.

## Timing
- Reset (asynchronous): count = 0, pointers = 0, state = IDLE, route register = 4, ovf = 0.
- Reset outputs: ordy = 1, bdata = 0, port = 4, ovch = VCHID.
- Push latency: a flit written at edge N is visible on `bdata` after edge N (zero-cycle bypass is not supported).
- Pop: `bdata` advances to the next entry after the popping edge, or becomes 0 if the buffer is now empty.
- `ordy` is registered-equivalent: it is high iff count < DEPTH at the start of the cycle. A push when count == DEPTH is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push and pop request with count == 0: only the push takes effect.
- Reset asserted mid-packet: the buffer empties and the FSM returns to IDLE immediately. In-flight flits are discarded.

## Configuration
- `IBUF_OVF_EN` defined:
  - ivalid & !ordy sets `ovf`, which stays high until reset.
  - The flit is dropped.
- `IBUF_OVF_EN` undefined:
  - `ovf` is tied to 0 and no flag register exists.
  - Overflowing flits are silently dropped.

## Test plan
- Reset check: after reset with ROUTERID = 5 and ARRAY_X = 4 → ordy = 1, bdata = 0, port = 4, ovf = 0.
- Routing: push a headtail flit with dst = 7 at ROUTERID = 5 → port = 0 the next cycle. Pop it → FSM in IDLE, bdata = 0.
- Port holding: push head (dst = 1), body, tail at ROUTERID = 5. Pop the head, then push a new head with dst = 13 → port stays 3 until the tail pops, then becomes 2.
- Fill: push DEPTH = 4 flits with no pop → ordy = 0 after the 4th edge. Then push and pop together → refused push, count = 3.
- Overflow: with `IBUF_OVF_EN`, ivalid while full → ovf = 1 and stays 1. Without the macro → ovf = 0.
- Stall: send = 1, grt = 1, irdy = 0 for 3 cycles → bdata unchanged and count unchanged. Raise irdy → one pop per cycle.

Source files
------------

// File: rtl/ibuf_rc.sv
// ibuf_rc: per-VC input buffer with XY route computation.
// Stores flits in a FIFO, shows the head flit on bdata and holds the
// computed output port stable for the duration of a packet.
// Optional feature macro: IBUF_OVF_EN (sticky overflow flag on ovf).

`ifndef DATAW
`define DATAW 31
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 31
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 30
`endif
`ifndef DST_MSB
`define DST_MSB 7
`endif
`ifndef DST_LSB
`define DST_LSB 4
`endif
`ifndef PORTW
`define PORTW 2
`endif
`ifndef VCHW
`define VCHW 1
`endif
// Flit type codes; body shares 00 with "none" so only head-type codes
// ever trigger routing on an empty buffer.
`ifndef TYPE_BODY
`define TYPE_BODY 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module ibuf_rc #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int VCHID    = 0,
    parameter int DEPTH    = 4,
    parameter int ARRAY_X  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`DATAW:0]   idata,
    input  logic              ivalid,
    output logic              ordy,
    output logic [`DATAW:0]   bdata,
    input  logic              send,
    input  logic              grt,
    input  logic              irdy,
    output logic [`PORTW:0]   port,
    output logic [`VCHW:0]    ovch,
    output logic              ovf
);

    localparam int PW     = $clog2(DEPTH) + 1;
    localparam int AW     = PW - 1;
    localparam int PORT_W = `PORTW + 1;
    localparam int VCH_W  = `VCHW + 1;
    localparam int DST_W  = `DST_MSB - `DST_LSB + 1;
    localparam int MY_X   = ROUTERID % ARRAY_X;
    localparam int MY_Y   = ROUTERID / ARRAY_X;

    localparam logic [PORT_W-1:0] P_XPOS  = PORT_W'(0);
    localparam logic [PORT_W-1:0] P_XNEG  = PORT_W'(1);
    localparam logic [PORT_W-1:0] P_YPOS  = PORT_W'(2);
    localparam logic [PORT_W-1:0] P_YNEG  = PORT_W'(3);
    localparam logic [PORT_W-1:0] P_LOCAL = PORT_W'(4);

    typedef enum logic {IDLE, ROUTED} state_t;

    logic [`DATAW:0]   mem [DEPTH];
    logic [PW-1:0]     wp, rp, cnt;
    logic              push, pop;
    logic [1:0]        head_type;
    logic              head_is_hdr;
    logic [PORT_W-1:0] xy_port, route_reg, route_nxt;
    state_t            state, state_nxt;

    // X-first dimension-order routing from a destination router id
    function automatic logic [PORT_W-1:0] xy_route(input logic [DST_W-1:0] dst);
        int dx, dy;
        dx = int'(dst) % ARRAY_X;
        dy = int'(dst) / ARRAY_X;
        if (dx > MY_X)      return P_XPOS;
        else if (dx < MY_X) return P_XNEG;
        else if (dy > MY_Y) return P_YPOS;
        else if (dy < MY_Y) return P_YNEG;
        else                return P_LOCAL;
    endfunction

    // Pointer increment wrapping modulo DEPTH
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ordy        = (cnt < PW'(DEPTH));
    assign push        = ivalid & ordy;
    assign pop         = send & grt & irdy & (cnt != '0);
    assign bdata       = (cnt != '0) ? mem[rp[AW-1:0]] : '0;
    assign head_type   = bdata[`TYPE_MSB:`TYPE_LSB];
    assign head_is_hdr = (head_type == `TYPE_HEAD) || (head_type == `TYPE_HEADTAIL);
    assign xy_port     = xy_route(bdata[`DST_MSB:`DST_LSB]);
    assign ovch        = VCH_W'(VCHID);

    // Flit storage: data only, never reset; bdata masks stale entries
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= idata;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= ptr_inc(wp);
            if (pop)  rp <= ptr_inc(rp);
            case ({push, pop})
                2'b10:   cnt <= cnt + PW'(1);
                2'b01:   cnt <= cnt - PW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Route state and route register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            route_reg <= P_LOCAL;
        end else begin
            state     <= state_nxt;
            route_reg <= route_nxt;
        end
    end

    // Next route state and port selection; route_reg doubles as the
    // "last value" holder when no header is at the head in IDLE
    always_comb begin
        state_nxt = state;
        route_nxt = route_reg;
        port      = route_reg;
        case (state)
            IDLE: begin
                if (head_is_hdr) begin
                    port      = xy_port;
                    route_nxt = xy_port;
                    if (pop && head_type == `TYPE_HEAD) state_nxt = ROUTED;
                end
            end
            ROUTED: begin
                if (pop && head_type == `TYPE_TAIL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef IBUF_OVF_EN
    logic ovf_reg;

    // Sticky overflow: any valid flit offered while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 ovf_reg <= 1'b0;
        else if (ivalid && !ordy) ovf_reg <= 1'b1;
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

endmodule
